// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding and frame constants for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    // XOR over data plus parity bit must equal this for a good frame
    localparam logic PARITY_ODD = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 2000;

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - synchronous receive FIFO with registered head output
module ps2_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    remain;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + AW'(do_pop);
    assign remain  = count - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head is registered: a push into an otherwise empty queue bypasses the array
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count  <= count + CW'(do_push) - CW'(do_pop);
            if (do_push && remain == '0) begin
                head <= din;
            end else begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 frame receiver with parity/framing checks and receive FIFO
// Optional receive watchdog built when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          ps2_clk_edge,
    input  logic                          ps2_data,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow,
    input  logic                          err_clr
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 parity_ok;
    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 abort;

    assign parity_ok = ((^{shift, par_bit}) == PARITY_ODD);
    assign push_req  = (state == ST_STOP) && ps2_clk_edge && !abort &&
                       parity_ok && (ps2_data == STOP_BIT);
    assign rx_valid  = (fifo_count != '0);
    assign pop       = rx_valid && rx_ready;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd;

    assign abort = (state != ST_IDLE) && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (abort || state == ST_IDLE || ps2_clk_edge) begin
                wd <= '0;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                shift   <= '0;
            end else if (ps2_clk_edge) begin
                case (state)
                    ST_IDLE: begin
                        if (ps2_data == START_BIT && enable) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        // LSB arrives first, so bits enter at the top and walk down
                        shift <= (shift >> 1) | (DATA_BITS'(ps2_data) << (DATA_BITS - 1));
                        if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= ps2_data;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        parity_err <= !parity_ok;
                        frame_err  <= (ps2_data != STOP_BIT);
                        state      <= ST_IDLE;
                        bit_cnt    <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // A new overflow outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end else if (err_clr) begin
            overflow <= 1'b0;
        end
    end

    ps2_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .din   (shift),
        .pop   (pop),
        .head  (rx_data),
        .count (fifo_count),
        .full  (full)
    );

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb/tb_ps2_frame_receiver.sv - directed self-checking bench for ps2_frame_receiver
module tb_ps2_frame_receiver;

    localparam int DB = 8;
    localparam int FD = 4;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          ps2_clk_edge = 1'b0;
    logic          ps2_data = 1'b1;
    logic          rx_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic [2:0]    fifo_count;
    logic          parity_err;
    logic          frame_err;
    logic          timeout_err;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_frame_receiver #(
        .DATA_BITS      (DB),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .ps2_clk_edge (ps2_clk_edge),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .fifo_count   (fifo_count),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err),
        .overflow     (overflow),
        .err_clr      (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic pop_now, input logic clr_now);
        tick();
        ps2_data     = b;
        ps2_clk_edge = 1'b1;
        rx_ready     = pop_now;
        err_clr      = clr_now;
        tick();
        ps2_clk_edge = 1'b0;
        rx_ready     = 1'b0;
        err_clr      = 1'b0;
        ps2_data     = 1'b1;
    endtask

    // Returns one cycle after the stop-bit edge
    task automatic send_frame(input logic [DB-1:0] d, input logic pflip, input logic stop_b,
                              input logic pop_at_stop, input logic clr_at_stop);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i], 1'b0, 1'b0);
        send_bit((~^d) ^ pflip, 1'b0, 1'b0);
        send_bit(stop_b, pop_at_stop, clr_at_stop);
    endtask

    task automatic pop_expect(input logic [DB-1:0] exp);
        check("pop_head", rx_data, exp);
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int  waited;
        logic seen;

        repeat (3) tick();
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_ovf", overflow, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        check("good_valid", rx_valid, 1);
        check("good_data", rx_data, 8'h1C);
        check("good_count", fifo_count, 1);
        check("good_perr", parity_err, 0);
        pop_expect(8'h1C);
        check("good_drained", rx_valid, 0);

        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_perr", parity_err, 1);
        check("par_ferr", frame_err, 0);
        check("par_count", fifo_count, 0);
        tick();
        check("par_pulse_end", parity_err, 0);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stop_ferr", frame_err, 1);
        check("stop_perr", parity_err, 0);
        check("stop_count", fifo_count, 0);
        tick();
        check("stop_pulse_end", frame_err, 0);

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        check("both_perr", parity_err, 1);
        check("both_ferr", frame_err, 1);

        enable = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        check("disabled_count", fifo_count, 0);
        enable = 1'b1;

        for (int k = 1; k <= 4; k++) send_frame(DB'(k), 1'b0, 1'b1, 1'b0, 1'b0);
        check("fill_count", fifo_count, 4);
        check("fill_ovf", overflow, 0);
        send_frame(8'h05, 1'b0, 1'b1, 1'b0, 1'b1);
        check("ovf_set_beats_clr", overflow, 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_head", rx_data, 8'h01);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        send_frame(8'h06, 1'b0, 1'b1, 1'b1, 1'b0);
        check("coinc_ovf", overflow, 0);
        check("coinc_count", fifo_count, 4);
        pop_expect(8'h02);
        pop_expect(8'h03);
        pop_expect(8'h04);
        pop_expect(8'h06);
        check("coinc_empty", fifo_count, 0);
        check("coinc_valid", rx_valid, 0);

`ifdef PS2_RX_TIMEOUT_EN
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        waited = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            tick();
            if (timeout_err) begin
                seen   = 1'b1;
                waited = i;
            end
        end
        check("to_seen", seen, 1);
        check("to_latency", waited, TO);
        check("to_count", fifo_count, 0);
        tick();
        check("to_pulse_end", timeout_err, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("to_next_data", rx_data, 8'hF0);
        check("to_next_count", fifo_count, 1);
        pop_expect(8'hF0);
`else
        waited = 0;
        seen   = 1'b0;
        check("to_disabled", timeout_err, 0);
`endif

        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", fifo_count, 2);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        tick();
        check("mid_rst_perr", parity_err, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_terr", timeout_err, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'hAA);
        check("post_rst_count", fifo_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
